// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter in front of a single memory slave.
// The winning master's request is latched on grant and held stable until the
// slave completes or the per-transaction timeout expires.
module bus_arbiter #(
    parameter int unsigned            ADDR_W    = 32,
    parameter int unsigned            DATA_W    = 32,
    parameter int unsigned            MASK_W    = 4,
    parameter logic [ADDR_W-1:0]      BASE_ADDR = 32'h8000_0000,
    parameter int unsigned            TIMEOUT   = 16
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              ibus_req,
    input  logic              ibus_we,
    input  logic [ADDR_W-1:0] ibus_addr,
    input  logic [DATA_W-1:0] ibus_wdata,
    input  logic [MASK_W-1:0] ibus_mask,
    output logic [DATA_W-1:0] ibus_rdata,
    output logic              ibus_ready,
    output logic              ibus_err,

    input  logic              dbus_req,
    input  logic              dbus_we,
    input  logic [ADDR_W-1:0] dbus_addr,
    input  logic [DATA_W-1:0] dbus_wdata,
    input  logic [MASK_W-1:0] dbus_mask,
    output logic [DATA_W-1:0] dbus_rdata,
    output logic              dbus_ready,
    output logic              dbus_err,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [MASK_W-1:0] mem_mask,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,

    output logic              busy
);

    // Counter only needs to reach TIMEOUT-1.
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StGntI = 2'd1,
        StGntD = 2'd2
    } state_e;

    state_e           state_q;
    logic             last_d_q;   // 1: data master won last, 0: instruction master
    logic [CNT_W-1:0] cnt_q;
    logic             mem_req_q;

    logic pick_d;
    logic granted;
    logic timed_out;
    logic done;

    // Round-robin tie-break: data wins a tie unless it was the last winner.
    assign pick_d    = dbus_req && (!ibus_req || !last_d_q);
    assign granted   = (state_q == StGntI) || (state_q == StGntD);
    // A slave completion in the timeout cycle wins over the timeout.
    assign timed_out = (TIMEOUT != 0) && granted && (cnt_q == CNT_LAST) && !mem_ready;
    assign done      = granted && (mem_ready || timed_out);

    assign mem_req = mem_req_q;
    assign busy    = mem_req_q;

    // Arbitration FSM, request latch and timeout counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            last_d_q  <= 1'b0;
            cnt_q     <= '0;
            mem_req_q <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_mask  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (ibus_req || dbus_req) begin
                        state_q   <= pick_d ? StGntD : StGntI;
                        last_d_q  <= pick_d;
                        cnt_q     <= '0;
                        mem_req_q <= 1'b1;
                        mem_we    <= pick_d ? dbus_we : ibus_we;
                        mem_addr  <= (pick_d ? dbus_addr : ibus_addr) - BASE_ADDR;
                        mem_wdata <= pick_d ? dbus_wdata : ibus_wdata;
                        mem_mask  <= pick_d ? dbus_mask : ibus_mask;
                    end
                end
                StGntI, StGntD: begin
                    if (done) begin
                        state_q   <= StIdle;
                        mem_req_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    // Completion steering back to the granted master; suppressed while in reset.
    always_comb begin
        ibus_ready = 1'b0;
        ibus_err   = 1'b0;
        ibus_rdata = '0;
        dbus_ready = 1'b0;
        dbus_err   = 1'b0;
        dbus_rdata = '0;
        if (!rst && done) begin
            if (state_q == StGntI) begin
                ibus_ready = 1'b1;
                ibus_err   = timed_out;
                ibus_rdata = timed_out ? '0 : mem_rdata;
            end else begin
                dbus_ready = 1'b1;
                dbus_err   = timed_out;
                dbus_rdata = timed_out ? '0 : mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with default parameters (TIMEOUT = 16).
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ibus_req, ibus_we, dbus_req, dbus_we;
    logic [31:0] ibus_addr, ibus_wdata, dbus_addr, dbus_wdata;
    logic [3:0]  ibus_mask, dbus_mask;
    logic [31:0] ibus_rdata, dbus_rdata;
    logic        ibus_ready, ibus_err, dbus_ready, dbus_err;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_mask;
    logic        mem_ready;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    bus_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .ibus_req   (ibus_req),
        .ibus_we    (ibus_we),
        .ibus_addr  (ibus_addr),
        .ibus_wdata (ibus_wdata),
        .ibus_mask  (ibus_mask),
        .ibus_rdata (ibus_rdata),
        .ibus_ready (ibus_ready),
        .ibus_err   (ibus_err),
        .dbus_req   (dbus_req),
        .dbus_we    (dbus_we),
        .dbus_addr  (dbus_addr),
        .dbus_wdata (dbus_wdata),
        .dbus_mask  (dbus_mask),
        .dbus_rdata (dbus_rdata),
        .dbus_ready (dbus_ready),
        .dbus_err   (dbus_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_mask   (mem_mask),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic exp_d [4];

    initial begin
        rst = 1'b1;
        ibus_req = 0; ibus_we = 0; ibus_addr = '0; ibus_wdata = '0; ibus_mask = '0;
        dbus_req = 0; dbus_we = 0; dbus_addr = '0; dbus_wdata = '0; dbus_mask = '0;
        mem_rdata = '0; mem_ready = 0;
        step(); step();
        #1;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_ibus_ready", 32'(ibus_ready), 32'd0);
        chk("rst_dbus_ready", 32'(dbus_ready), 32'd0);
        chk("rst_ibus_rdata", ibus_rdata, 32'h0);

        // Single instruction read, slave ready on the first grant cycle.
        rst = 0;
        ibus_req = 1; ibus_addr = 32'h8000_0010;
        step();
        ibus_req = 0; mem_ready = 1; mem_rdata = 32'h0000_0013;
        #1;
        chk("rd_mem_req", 32'(mem_req), 32'd1);
        chk("rd_busy", 32'(busy), 32'd1);
        chk("rd_mem_addr", mem_addr, 32'h10);
        chk("rd_ibus_ready", 32'(ibus_ready), 32'd1);
        chk("rd_ibus_rdata", ibus_rdata, 32'h13);
        chk("rd_ibus_err", 32'(ibus_err), 32'd0);
        chk("rd_dbus_ready", 32'(dbus_ready), 32'd0);
        chk("rd_dbus_rdata", dbus_rdata, 32'h0);
        step();
        #1;
        chk("rd_idle_mem_req", 32'(mem_req), 32'd0);
        chk("rd_idle_ready", 32'(ibus_ready), 32'd0);

        // Both masters requesting from reset: D, I, D, I.
        rst = 1; mem_ready = 1; mem_rdata = 32'h0000_00AA;
        ibus_req = 1; dbus_req = 1;
        ibus_addr = 32'h8000_0004; dbus_addr = 32'h8000_0008;
        step();
        rst = 0;
        exp_d[0] = 1; exp_d[1] = 0; exp_d[2] = 1; exp_d[3] = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("rr_dbus_ready", 32'(dbus_ready), 32'(exp_d[k]));
            chk("rr_ibus_ready", 32'(ibus_ready), 32'(!exp_d[k]));
            chk("rr_mem_addr", mem_addr, exp_d[k] ? 32'h8 : 32'h4);
            step();
            // Idle cycle: mem_ready high here must not produce a pulse.
            chk("rr_idle_i", 32'(ibus_ready), 32'd0);
            chk("rr_idle_d", 32'(dbus_ready), 32'd0);
        end
        ibus_req = 0; dbus_req = 0; mem_ready = 0;
        step();

        // Data write with a 3-cycle slave wait; master inputs change meanwhile.
        dbus_req = 1; dbus_we = 1; dbus_addr = 32'h8000_0100;
        dbus_wdata = 32'hCAFE_BABE; dbus_mask = 4'b0011;
        step();
        dbus_req = 0; dbus_we = 0; dbus_addr = 32'h8000_0FFF;
        dbus_wdata = 32'h0; dbus_mask = 4'b1111;
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) begin
                mem_ready = 1; mem_rdata = 32'h0000_0005;
            end
            #1;
            chk("wr_mem_addr", mem_addr, 32'h100);
            chk("wr_mem_we", 32'(mem_we), 32'd1);
            chk("wr_mem_mask", 32'(mem_mask), 32'h3);
            chk("wr_mem_wdata", mem_wdata, 32'hCAFE_BABE);
            chk("wr_dbus_ready", 32'(dbus_ready), 32'(c == 3));
            step();
        end
        mem_ready = 0;
        #1;
        chk("wr_after_mem_req", 32'(mem_req), 32'd0);

        // Timeout with the slave stuck.
        dbus_req = 1; dbus_addr = 32'h8000_0200; mem_rdata = 32'hDEAD_BEEF;
        step();
        dbus_req = 0;
        for (int c = 1; c <= 16; c++) begin
            #1;
            chk("to_dbus_ready", 32'(dbus_ready), 32'(c == 16));
            if (c == 16) begin
                chk("to_dbus_err", 32'(dbus_err), 32'd1);
                chk("to_dbus_rdata", dbus_rdata, 32'h0);
            end
            step();
        end
        chk("to_after_mem_req", 32'(mem_req), 32'd0);
        chk("to_after_busy", 32'(busy), 32'd0);

        // Slave completes exactly in the timeout cycle: normal completion.
        ibus_req = 1; ibus_addr = 32'h8000_0300;
        step();
        ibus_req = 0;
        for (int c = 1; c <= 16; c++) begin
            if (c == 16) begin
                mem_ready = 1; mem_rdata = 32'h1234_5678;
            end
            #1;
            chk("edge_ibus_ready", 32'(ibus_ready), 32'(c == 16));
            if (c == 16) begin
                chk("edge_ibus_err", 32'(ibus_err), 32'd0);
                chk("edge_ibus_rdata", ibus_rdata, 32'h1234_5678);
            end
            step();
        end
        mem_ready = 0;

        // Reset pulse in the second cycle of an instruction grant.
        ibus_req = 1; ibus_addr = 32'h8000_0400;
        step();
        #1;
        chk("ab_c1_mem_req", 32'(mem_req), 32'd1);
        chk("ab_c1_ready", 32'(ibus_ready), 32'd0);
        step();
        rst = 1; mem_ready = 1;
        #1;
        chk("ab_rst_ibus_ready", 32'(ibus_ready), 32'd0);
        chk("ab_rst_dbus_ready", 32'(dbus_ready), 32'd0);
        chk("ab_rst_ibus_rdata", ibus_rdata, 32'h0);
        step();
        rst = 0; mem_ready = 0;
        #1;
        chk("ab_post_mem_req", 32'(mem_req), 32'd0);
        chk("ab_post_busy", 32'(busy), 32'd0);
        chk("ab_post_ready", 32'(ibus_ready), 32'd0);
        step();
        mem_ready = 1; mem_rdata = 32'h0000_0077;
        #1;
        chk("ab_regrant_mem_req", 32'(mem_req), 32'd1);
        chk("ab_regrant_addr", mem_addr, 32'h400);
        chk("ab_regrant_ready", 32'(ibus_ready), 32'd1);
        chk("ab_regrant_rdata", ibus_rdata, 32'h77);
        ibus_req = 0;
        step();
        mem_ready = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter MASK_W, default 4, byte-mask width.
REQ-004 SHALL have parameter BASE_ADDR, default 32'h8000_0000, subtracted from master address before forwarding.
REQ-005 SHALL have parameter TIMEOUT, default 16, max cycles per granted transaction; 0 disables timeout.
REQ-006 SHALL have one clock and one reset: clk  input  1  sole clock, all logic on rising edge; rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have ibus_req  input  1  instruction master request; ibus_we  input  1  write enable; ibus_addr  input  ADDR_W  address; ibus_wdata  input  DATA_W  write data; ibus_mask  input  MASK_W  byte mask.
REQ-008 SHALL have ibus_rdata  output  DATA_W  read data; ibus_ready  output  1  one-cycle completion pulse; ibus_err  output  1  timeout flag, valid with ibus_ready.
REQ-009 SHALL have dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_mask, dbus_rdata, dbus_ready, dbus_err with the same directions, widths and meanings for the data master.
REQ-010 SHALL have mem_req  output  1  slave request; mem_we  output  1; mem_addr  output  ADDR_W; mem_wdata  output  DATA_W; mem_mask  output  MASK_W; mem_rdata  input  DATA_W; mem_ready  input  1  slave completion.
REQ-011 SHALL have busy  output  1  high while a grant is active.

Function
REQ-012 SHALL implement FSM states IDLE, GNT_I, GNT_D.
REQ-013 IDLE: only ibus_req -> GNT_I; only dbus_req -> GNT_D; neither -> stay IDLE.
REQ-014 IDLE, both requests same cycle: grant the master not granted last (round-robin); last_grant register resets to I, so first tie goes to D.
REQ-015 On the IDLE->GNT_x edge SHALL register winner's we, addr-BASE_ADDR (modulo 2^ADDR_W), wdata, mask into mem_we/mem_addr/mem_wdata/mem_mask, and update last_grant.
REQ-016 In GNT_x SHALL drive mem_req=1 and busy=1; mem_* fields held stable for whole grant regardless of master inputs.
REQ-017 In GNT_x with mem_ready=1: x_ready=1 same cycle, x_rdata=mem_rdata combinationally, x_err=0, next state IDLE.
REQ-018 Minimum latency: request at cycle N, mem_req at N+1, x_ready at N+1 if mem_ready at N+1; master may re-request, next grant no earlier than N+2.
REQ-019 Non-granted master's ready/err SHALL be 0 and its rdata 0.
REQ-020 Master deasserting req during its grant SHALL be ignored; the latched transaction completes.
REQ-021 Timeout counter SHALL clear on entry to GNT_x and increment each GNT_x cycle without mem_ready.
REQ-022 If TIMEOUT!=0 and counter reaches TIMEOUT-1 with mem_ready=0: x_ready=1, x_err=1, x_rdata=0, next state IDLE; mem_req drops next cycle.
REQ-023 mem_ready simultaneous with timeout cycle SHALL be a normal completion (err=0).
REQ-024 mem_ready in IDLE SHALL be ignored.
REQ-025 Write transactions SHALL complete identically to reads; x_rdata on writes is mem_rdata, don't-care to master.

Reset
REQ-026 rst=1 SHALL force IDLE, last_grant=I, counter=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_mask=0, busy=0.
REQ-027 During and after reset all ready/err=0 and rdata=0.
REQ-028 rst asserted mid-grant SHALL abort with no ready pulse to either master; the first cycle after rst deassert is IDLE.

Verification
REQ-029 Single ibus read addr 32'h8000_0010, mem_ready at first grant cycle with mem_rdata 32'h0000_0013 -> mem_addr=32'h10, ibus_ready 1 cycle, ibus_rdata=32'h13, dbus_ready=0.
REQ-030 ibus_req and dbus_req held high together from reset for 4 transactions, mem_ready=1 always -> grant order D,I,D,I, one ready pulse each.
REQ-031 dbus write addr 32'h8000_0100, wdata 32'hCAFE_BABE, mask 4'b0011, master changes addr during 3-cycle slave wait -> mem_addr=32'h100, mem_we=1, mem_mask=4'b0011, fields stable, dbus_ready on 3rd grant cycle.
REQ-032 TIMEOUT=16, mem_ready stuck 0 -> dbus_ready=1, dbus_err=1, dbus_rdata=0 on 16th grant cycle; mem_req=0 next cycle.
REQ-033 mem_ready asserted on exactly the 16th grant cycle -> ready=1, err=0, rdata=mem_rdata.
REQ-034 rst pulsed 1 cycle during 2nd cycle of an ibus grant -> no ibus_ready, mem_req=0 and busy=0 after reset, pending ibus_req re-granted from IDLE.
